div_unit: RTL
=============

# div_unit

Iterative multi-cycle integer divider for the execute stage. It implements UDIV/SDIV, the inverse of the ALU's single-cycle MUL path. It accepts a dividend/divisor pair on a start pulse and runs a radix-2 restoring loop, one quotient bit per cycle. It returns quotient, remainder and a 5-bit flag vector in the ALU flag layout {N,Z,C,V,Q}. The hazard unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `is_signed`  in  1  1 = SDIV (two's complement), 0 = UDIV; captured with `start`.
- `a`  in  WIDTH  dividend; captured with `start`.
- `b`  in  WIDTH  divisor; captured with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; results valid in this cycle.
- `quotient`  out  WIDTH  result quotient.
- `remainder`  out  WIDTH  result remainder; its sign follows the dividend.
- `flags`  out  5  {N,Z,C,V,Q}.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On `start`, latch `is_signed`, |a|, |b| (magnitudes only if signed), and the result signs: q_neg = a[W-1]^b[W-1], r_neg = a[W-1].
  - If b==0 -> DONE. Otherwise -> RUN with iteration counter = WIDTH-1.
- RUN, one step per cycle:
  - Shift {rem,dq} left by 1.
  - Trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtraction.
  - If the trial result is non-negative, keep it and set the quotient LSB.
  - Counter decrements; at 0 -> FIX.
- FIX:
  - Negate quotient if q_neg, negate remainder if r_neg (signed mode only).
  - Register the outputs and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. A `start` seen in DONE is accepted, because `busy`=0 there.
- Divide by zero: quotient=0, remainder=a (unmodified), flags={0,1,0,0,0}.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF):
  - quotient=0x80000000, remainder=0, V=1.
  - The natural unsigned-magnitude datapath yields this quotient; V is set by explicit detection.
- Flags: N = quotient[W-1], Z = (quotient==0), C = 0, V = signed overflow only, Q = 0.
- `quotient`, `remainder` and `flags` hold their last values until the next FIX or DONE update. They are not cleared on `start`.
- `start` while `busy`=1 is ignored and has no side effects.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `flags`=0, state=IDLE.
- Normal operation, with `start` sampled at edge T0:
  - `busy`=1 from T0+1 through the FIX cycle.
  - RUN occupies T0+1..T0+WIDTH.
  - FIX occupies T0+WIDTH+1.
  - `done`=1 in cycle T0+WIDTH+2 (34 cycles for WIDTH=32).
- Divide by zero: `done`=1 at T0+1 and `busy` never rises.
- Back-to-back operations: a `start` in the DONE cycle gives `busy`=1 on the next cycle. There are no dead cycles.
- Reset asserted mid-operation: the next edge forces IDLE and clears every output. Partial results are discarded and no `done` is produced.
- Reset and `start` in the same cycle: reset wins.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE,RUN,FIX,DONE};
  - `DIV_WIDTH`=32;
  - flag bit index constants FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_Q=0, shared with the ALU flag consumer;
  - `INT_MIN` constant.
- One sub-module, `div_step`: combinational single restoring step. Inputs: rem, dividend MSB, divisor magnitude. Outputs: next rem and quotient bit. This keeps the FSM file control-only.
- Counter width: $clog2(WIDTH).

## Test plan
- Unsigned 100/7 -> quotient=14, remainder=2, flags=0, `done` exactly 34 cycles after `start`.
- Signed -7/2 (0xFFFFFFF9/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, N=1, Z=0.
- Divide by zero, a=0x1234 -> quotient=0, remainder=0x1234, flags=5'b01000, `done` one cycle after `start`, `busy` never high.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, flags=5'b10010.
- Second `start` asserted at cycle 10 of a running 100/7 -> ignored; the result is still 14/2. Then a `start` in the DONE cycle with 9/3 -> quotient=3 34 cycles later.
- Reset pulsed at cycle 20 of an operation -> next cycle: `busy`=0, all outputs 0, no `done` pulse.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider and its flag consumers.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;

  localparam int DIV_WIDTH = 32;

  // Bit positions inside the {N,Z,C,V,Q} flag vector, common with the ALU
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  // rem < dvs on entry, so a non-negative diff always fits back in WIDTH bits
  assign shl     = {rem, msb};
  assign diff    = shl - {1'b0, dvs};
  assign qbit    = ~diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle UDIV/SDIV: sign-magnitude front end, WIDTH restoring steps, sign fix-up.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e      state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] rem, dq, dvs;
  logic            sgn, q_neg, r_neg, ovf;

  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, q_fix, r_fix;
  logic             qbit;

  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    q_fix = (sgn && q_neg) ? -dq  : dq;
    r_fix = (sgn && r_neg) ? -rem : rem;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .msb     (dq[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] q, input logic v);
    logic [4:0] f;
    f         = '0;
    f[FLAG_N] = q[WIDTH-1];
    f[FLAG_Z] = (q == '0);
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = v;
    f[FLAG_Q] = 1'b0;
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      flags     <= '0;
      cnt       <= '0;
      rem       <= '0;
      dq        <= '0;
      dvs       <= '0;
      sgn       <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        // DONE drops busy, so it accepts a new request exactly like IDLE
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            sgn   <= is_signed;
            q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg <= a[WIDTH-1];
            ovf   <= is_signed && (a == SMIN) && (b == '1);
            rem   <= '0;
            dq    <= a_mag;
            dvs   <= b_mag;
            cnt   <= CW'(WIDTH-1);
            if (b == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '0;
              remainder <= a;
              flags     <= mk_flags('0, 1'b0);
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dq  <= {dq[WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          flags     <= mk_flags(q_fix, ovf);
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
